// File: rtl/board_debug_monitor_pkg.sv
// Shared constants, types and helpers for the board debug monitor.
package board_dbg_pkg;

  localparam int CLK_HZ_DEF    = 50_000_000;
  localparam int TICK_HZ_DEF   = 1;
  localparam int DB_CYCLES_DEF = 1_000_000;
  localparam int NPROBE_DEF    = 4;
  localparam int LED_W_DEF     = 7;
  localparam int STALL_N_DEF   = 8;

  typedef logic [31:0] word_t;

  // Debounced button level; the encoding doubles as the stable output value.
  typedef enum logic {
    BTN_UP   = 1'b0,
    BTN_DOWN = 1'b1
  } btn_state_t;

  // Probe-select width; a one-bit select is kept even for tiny channel counts.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_debug_monitor_if.sv
// Board-side signal bundle: operator inputs, processor taps, and indicators.
interface board_debug_monitor_if
  import board_dbg_pkg::*;
#(
  parameter int NPROBE = NPROBE_DEF,
  parameter int LED_W  = LED_W_DEF
) ();

  localparam int SEL_W = sel_width(NPROBE);

  logic                  run_mode;
  logic                  step_btn;
  logic                  sel_btn;
  word_t                 pc;
  logic [NPROBE*32-1:0]  probe;
  logic                  cpu_en;
  logic                  pc_led;
  logic                  stall_led;
  logic [SEL_W-1:0]      sel;
  logic [LED_W-1:0]      led;

  // Board / processor side: drives switches, buttons and the observed buses.
  modport master (
    output run_mode, step_btn, sel_btn, pc, probe,
    input  cpu_en, pc_led, stall_led, sel, led
  );

  // Monitor side.
  modport slave (
    input  run_mode, step_btn, sel_btn, pc, probe,
    output cpu_en, pc_led, stall_led, sel, led
  );

endinterface

// File: rtl/board_debug_monitor_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability-window debouncer and
// single-cycle press pulse on the debounced rising edge.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   BTN_UP   | debounced level 0; counting samples of 1 toward a press
//   BTN_DOWN | debounced level 1; counting samples of 0 toward a release
module btn_debounce
  import board_dbg_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  btn_state_t       state;

  // Synchronize, then accept a new level only after a full window of agreeing
  // samples; any sample matching the current level restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      state <= BTN_UP;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      case (state)
        BTN_UP: begin
          if (sync[1]) begin
            if (cnt == CNT_W'(DB_CYCLES - 1)) begin
              state <= BTN_DOWN;
              cnt   <= '0;
              press <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        BTN_DOWN: begin
          if (!sync[1]) begin
            if (cnt == CNT_W'(DB_CYCLES - 1)) begin
              state <= BTN_UP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          state <= BTN_UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/board_debug_monitor.sv
// Board debug monitor: paces the processor through a clock enable (free-run
// tick or debounced single step), watches the PC for progress/stall, and
// shows the low bits of a selectable probe channel on the LEDs.
module board_debug_monitor
  import board_dbg_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int TICK_HZ   = TICK_HZ_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int NPROBE    = NPROBE_DEF,
  parameter int LED_W     = LED_W_DEF,
  parameter int STALL_N   = STALL_N_DEF
) (
  input logic             clk,
  input logic             reset,
  board_debug_monitor_if.slave dbg
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int TICK_W  = $clog2(DIV);
  localparam int STALL_W = $clog2(STALL_N + 1);
  localparam int SEL_W   = sel_width(NPROBE);

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [1:0]         run_sync;
  logic               step_press;
  logic               sel_press;
  logic               cpu_en;
  logic               sample_en;
  word_t              pc_prev;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_nxt;
  logic               pc_led;
  logic               stall_led;
  logic [SEL_W-1:0]   sel;
  logic [LED_W-1:0]   led;
  logic [LED_W-1:0]   led_nxt;
  logic               unused_probe;

  assign tick = (tick_cnt == TICK_W'(DIV - 1));

  // Free-running step-rate divider; it never gates a clock, only an enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Bring the run/step switch into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run_sync <= '0;
    else       run_sync <= {run_sync[0], dbg.run_mode};
  end

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (clk),
    .reset (reset),
    .raw   (dbg.step_btn),
    .press (step_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_sel_db (
    .clk   (clk),
    .reset (reset),
    .raw   (dbg.sel_btn),
    .press (sel_press)
  );

  // Processor enable from the selected source; sample_en trails it so the PC
  // seen at compare time is the one the processor produced on that step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_en    <= 1'b0;
      sample_en <= 1'b0;
    end else begin
      cpu_en    <= run_sync[1] ? tick : step_press;
      sample_en <= cpu_en;
    end
  end

  // Stall count after this cycle's sample (unchanged when not sampling).
  always_comb begin
    stall_nxt = stall_cnt;
    if (sample_en) begin
      if (dbg.pc != pc_prev)                     stall_nxt = '0;
      else if (stall_cnt != STALL_W'(STALL_N))   stall_nxt = stall_cnt + 1'b1;
    end
  end

  // PC progress tracking: toggle on change, count consecutive unchanged steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_prev   <= '0;
      pc_led    <= 1'b0;
      stall_cnt <= '0;
      stall_led <= 1'b0;
    end else begin
      if (sample_en) begin
        pc_prev <= dbg.pc;
        if (dbg.pc != pc_prev) pc_led <= ~pc_led;
      end
      stall_cnt <= stall_nxt;
      stall_led <= (stall_nxt == STALL_W'(STALL_N));
    end
  end

  // Probe channel select, cycling through the channels on each press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                sel <= '0;
    else if (sel_press) begin
      if (sel == SEL_W'(NPROBE - 1))          sel <= '0;
      else                                    sel <= sel + 1'b1;
    end
  end

  // Low bits of the selected channel.
  always_comb begin
    led_nxt = '0;
    for (int k = 0; k < NPROBE; k++) begin
      if (sel == k[SEL_W-1:0]) led_nxt = dbg.probe[32*k +: LED_W];
    end
  end

  // LED register refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) led <= '0;
    else       led <= led_nxt;
  end

  // Upper probe bits are intentionally not displayed.
  assign unused_probe = ^dbg.probe;

  assign dbg.cpu_en    = cpu_en;
  assign dbg.pc_led    = pc_led;
  assign dbg.stall_led = stall_led;
  assign dbg.sel       = sel;
  assign dbg.led       = led;

endmodule

// File: doc/board_debug_monitor.md
BOARD_DEBUG_MONITOR -- requirements
Module: board_debug_monitor

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 1, free-run step rate; DIV = CLK_HZ/TICK_HZ, DIV >= 2.
REQ-003 SHALL have parameter DB_CYCLES, default 1_000_000, debounce stability window in clk cycles, >= 2.
REQ-004 SHALL have parameter NPROBE, default 4, number of 32-bit probe channels, >= 2.
REQ-005 SHALL have parameter LED_W, default 7, LED count, 1..32.
REQ-006 SHALL have parameter STALL_N, default 8, consecutive unchanged-PC steps before stall indication, >= 1.
REQ-007 clk  input  1  single system clock; all logic on posedge clk.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 run_mode  input  1  1 = free-run at TICK_HZ, 0 = single-step; asynchronous.
REQ-010 step_btn  input  1  raw step button, active-high, asynchronous, bouncing.
REQ-011 sel_btn  input  1  raw probe-select button, active-high, asynchronous, bouncing.
REQ-012 pc  input  32  processor program counter.
REQ-013 probe  input  NPROBE*32  probe channels, channel k at bits [32k+31:32k].
REQ-014 cpu_en  output  1  one-cycle clock-enable pulse to the processor.
REQ-015 pc_led  output  1  toggles on each observed PC change.
REQ-016 stall_led  output  1  high while PC unchanged for STALL_N consecutive steps.
REQ-017 sel  output  clog2(NPROBE)  currently displayed probe channel.
REQ-018 led  output  LED_W  low LED_W bits of selected probe channel.

Function
REQ-019 Tick counter SHALL count 0..DIV-1 and wrap to 0; tick SHALL be high for exactly the cycle the counter equals DIV-1.
REQ-020 Block SHALL NOT generate a derived clock; processor advance is via cpu_en only.
REQ-021 run_mode, step_btn, sel_btn SHALL each pass a 2-flop synchronizer before use.
REQ-022 Each button debouncer SHALL update its stable state only after DB_CYCLES consecutive identical synchronized samples differing from it; any mismatch restarts the count.
REQ-023 Debouncer SHALL emit a one-cycle press pulse in the cycle its stable state goes 0->1; release SHALL produce no pulse.
REQ-024 cpu_en SHALL equal tick when synchronized run_mode=1 and step press pulse when 0; the unselected source SHALL be ignored.
REQ-025 sample_en SHALL be cpu_en delayed one cycle; PC compare SHALL occur only on sample_en.
REQ-026 On sample_en with pc != pc_prev: pc_led SHALL toggle, stall count SHALL clear to 0.
REQ-027 On sample_en with pc == pc_prev: stall count SHALL increment, saturating at STALL_N.
REQ-028 On every sample_en pc_prev SHALL load pc.
REQ-029 stall_led SHALL be registered high exactly when stall count == STALL_N.
REQ-030 sel press pulse SHALL advance sel by 1, wrapping from NPROBE-1 to 0.
REQ-031 led SHALL be registered each cycle from probe[32*sel +: LED_W], one-cycle latency after sel or probe change.
REQ-032 Simultaneous step and sel presses SHALL both take effect in the same cycle.
REQ-033 run_mode change SHALL take effect within 2 cycles; an in-flight sample_en SHALL still complete.

Reset
REQ-034 While reset is high: tick counter, stall count, sel, pc_prev, led, pc_led, stall_led, cpu_en, sample_en, synchronizers and debouncer states/counters SHALL be 0.
REQ-035 Reset asserted mid-debounce or mid-tick SHALL discard partial counts; first tick SHALL occur DIV cycles after reset deassertion.

Structure
REQ-036 Package board_dbg_pkg SHALL hold default parameter constants and a function for the sel width (clog2 with minimum 1).
REQ-037 One sub-module, btn_debounce (synchronizer + debouncer + press pulse), SHALL be instanced twice.

Verification (CLK_HZ=10, TICK_HZ=1, DB_CYCLES=3, NPROBE=3, LED_W=4, STALL_N=2)
REQ-038 run_mode=1, pc incrementing by 4 each cpu_en -> cpu_en pulses at cycles 10,20,30 after reset release; pc_led toggles one cycle after each.
REQ-039 run_mode=0, step_btn bounce 1,0,1 then held 5 cycles -> exactly one cpu_en; held 2 cycles only -> no cpu_en.
REQ-040 pc held at 0x40 for 3 steps -> stall_led high after second unchanged sample, stays high; pc->0x44 -> stall_led low after next sample.
REQ-041 probe = {0xC,0xB,0xA} channels 2..0, four sel presses -> sel 1,2,0,1; led 0xB,0xC,0xA,0xB.
REQ-042 reset asserted at tick counter 7 with sel=2 -> all outputs 0 immediately; first cpu_en 10 cycles after release.
REQ-043 run_mode=1 with step presses -> step ignored, cpu_en only on ticks.
